pipe_hazard_ctrl: RTL

- Parametrised stall/flush controller for the in-order RISC-V pipeline. It is the successor to the fixed 6-bit priority stall decoder.
- Merges N stall requesters, each with a configurable stall depth, into a per-stage stall vector.
- Generates a multi-cycle redirect flush window, which freezes while a deeper stall is active.
- Keeps saturating per-requester stall-cycle counters and a sticky deadlock watchdog.

---
 rtl/pipe_hazard_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the in-order pipeline: merges stall requesters into a
// per-stage freeze vector, times the redirect flush window, and keeps stall statistics.
module pipe_hazard_ctrl #(
    parameter int                    NUM_STAGES       = 6,
    parameter int                    NUM_REQ          = 4,
    parameter logic [4*NUM_REQ-1:0]  REQ_DEPTH        = {4'd4, 4'd2, 4'd1, 4'd1},
    parameter int                    REDIRECT_DEPTH   = 2,
    parameter int                    REDIRECT_PENALTY = 2,
    parameter int                    CNT_W            = 16,
    parameter int                    TIMEOUT          = 1024,
    localparam int                   SEL_W            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [NUM_REQ-1:0]    stall_req,
    input  logic                  redirect,
    input  logic [SEL_W-1:0]      cnt_sel,
    input  logic                  cnt_clr,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  flushing,
    output logic [CNT_W-1:0]      cnt_out,
    output logic                  deadlock
);

    localparam int PEN_W = $clog2(REDIRECT_PENALTY + 1);
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    function automatic logic [NUM_STAGES-1:0] range_mask(input int lo, input int hi);
        logic [NUM_STAGES-1:0] m;
        for (int j = 0; j < NUM_STAGES; j++) begin
            m[j] = (j >= lo) && (j <= hi);
        end
        return m;
    endfunction

    localparam logic [NUM_STAGES-1:0] FLUSH_BITS = range_mask(1, REDIRECT_DEPTH);

    logic [NUM_STAGES-1:0] mask;
    logic                  frozen;
    logic                  active;
    logic [PEN_W-1:0]      pen_cnt;
    logic [CNT_W-1:0]      counters [NUM_REQ];
    logic [WD_W-1:0]       wd_cnt;
    logic                  deadlock_q;

    // A requester deeper than the flush region freezes the flush window in place.
    always_comb begin
        mask   = '0;
        frozen = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (stall_req[i]) begin
                mask = mask | range_mask(0, int'(REQ_DEPTH[i*4 +: 4]));
                if (int'(REQ_DEPTH[i*4 +: 4]) > REDIRECT_DEPTH) begin
                    frozen = 1'b1;
                end
            end
        end
    end

    assign active = (pen_cnt != '0) && !frozen;

    always_comb begin
        stall    = '0;
        flush    = '0;
        flushing = 1'b0;
        if (!rst) begin
            if (!rdy) begin
                stall = '1;
            end else if (active) begin
                stall    = mask & ~FLUSH_BITS;
                flush    = FLUSH_BITS;
                flushing = 1'b1;
            end else begin
                stall = mask;
            end
        end
    end

    // A new redirect restarts the window rather than extending it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pen_cnt <= '0;
        end else if (rdy) begin
            if (redirect) begin
                pen_cnt <= PEN_W'(REDIRECT_PENALTY);
            end else if (active) begin
                pen_cnt <= pen_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                counters[i] <= '0;
            end
        end else if (rdy) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (cnt_clr) begin
                    counters[i] <= '0;
                end else if (stall_req[i] && (counters[i] != '1)) begin
                    counters[i] <= counters[i] + 1'b1;
                end
            end
        end
    end

    assign cnt_out = (32'(cnt_sel) < NUM_REQ) ? counters[cnt_sel] : '0;

    // A nonzero mask is exactly the condition for a nonzero stall on rdy cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt     <= '0;
            deadlock_q <= 1'b0;
        end else if (rdy && (TIMEOUT != 0)) begin
            if (mask != '0) begin
                if (wd_cnt == WD_W'(TO_M1)) begin
                    deadlock_q <= 1'b1;
                end
                if (wd_cnt != WD_W'(TIMEOUT)) begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end else begin
                wd_cnt <= '0;
            end
        end
    end

    assign deadlock = deadlock_q & ~rst;

endmodule
